// File: rtl/rom_loader_pkg.sv
// Shared constants for the boot ROM loader: flash opcode, image map and FSM states.
package rom_loader_pkg;

  localparam logic [7:0]  SPI_READ       = 8'h03;
  localparam logic [15:0] ROM128         = 16'h0000;
  localparam logic [15:0] ROM48          = 16'h8000;
  localparam logic [15:0] ESX            = 16'hC000;
  localparam logic [15:0] DEFAULT_LENGTH = 16'hE000;
  localparam logic [23:0] DEFAULT_FADDR  = 24'h100000;

  typedef enum logic [1:0] {
    START,
    CMD,
    DATA,
    DONE
  } state_t;

endpackage

// File: rtl/rom_loader_if.sv
// SPI flash pins plus the memory init bus driven by the loader.
interface rom_loader_if;
  logic        spiCs;
  logic        spiCk;
  logic        spiDo;
  logic        spiDi;
  logic        iniBusy;
  logic        iniWr;
  logic [7:0]  iniD;
  logic [15:0] iniA;

  modport master (
    output spiCs, spiCk, spiDo, iniBusy, iniWr, iniD, iniA,
    input  spiDi
  );

  modport slave (
    input  spiCs, spiCk, spiDo, iniBusy, iniWr, iniD, iniA,
    output spiDi
  );
endinterface

// File: rtl/rom_loader_spi_shifter.sv
// Tick divider and SPI mode-0 bit engine: 32-bit MOSI shifter, 8-bit MISO
// collector and a rising-edge counter used for command/byte boundaries.
module rom_loader_spi_shifter #(
  parameter int DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic        active,
  input  logic        load,
  input  logic        stop,
  input  logic        rx_en,
  input  logic [31:0] load_val,
  input  logic        spi_di,
  output logic        tick,
  output logic        cmd_last,
  output logic        byte_done,
  output logic        spi_ck,
  output logic        spi_do,
  output logic [7:0]  rx_next
);

  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [31:0]   tx;
  logic [7:0]    rx;
  logic [4:0]    edges;
  logic          rise;

  assign tick      = run && (cnt == CNT_MAX);
  assign rise      = tick && active && !spi_ck;
  // The edge counter wraps at 32, so data bytes line up on edges[2:0].
  assign cmd_last  = rise && (edges == 5'd31);
  assign byte_done = rise && rx_en && (edges[2:0] == 3'd7);
  assign rx_next   = {rx[6:0], spi_di};
  assign spi_do    = tx[31];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      spi_ck <= 1'b0;
      tx     <= '0;
      rx     <= '0;
      edges  <= '0;
    end else begin
      if (!run || cnt == CNT_MAX) cnt <= '0;
      else                        cnt <= cnt + 1'b1;

      if (load) begin
        tx    <= load_val;
        edges <= '0;
      end

      if (stop) begin
        spi_ck <= 1'b0;
      end else if (tick && active) begin
        spi_ck <= !spi_ck;
        if (spi_ck) begin
          tx <= {tx[30:0], 1'b0};
        end else begin
          rx    <= rx_next;
          edges <= edges + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Boot-time loader: reads LENGTH bytes from SPI flash at FADDR and writes them
// to the memory init port, holding iniBusy until the last byte is written.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [23:0] FADDR  = DEFAULT_FADDR,
  parameter logic [15:0] LENGTH = DEFAULT_LENGTH,
  parameter int          DIV    = 2
) (
  input  logic          clock,
  input  logic          reset,
  rom_loader_if.master  bus
);

  state_t      state, next_state;
  logic        tick, cmd_last, byte_done, spi_ck, spi_do;
  logic        load, stop, last_wr;
  logic [7:0]  rx_next;
  logic [15:0] index;
  logic        spi_cs, ini_busy, ini_wr;
  logic [7:0]  ini_d;
  logic [15:0] ini_a;

  assign last_wr = ini_wr && (index == LENGTH - 16'd1);

  rom_loader_spi_shifter #(.DIV(DIV)) u_shifter (
    .clock     (clock),
    .reset     (reset),
    .run       (state != DONE),
    .active    (state == CMD || state == DATA),
    .load      (load),
    .stop      (stop),
    .rx_en     (state == DATA),
    .load_val  ({SPI_READ, FADDR}),
    .spi_di    (bus.spiDi),
    .tick      (tick),
    .cmd_last  (cmd_last),
    .byte_done (byte_done),
    .spi_ck    (spi_ck),
    .spi_do    (spi_do),
    .rx_next   (rx_next)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    stop       = 1'b0;
    case (state)
      START: begin
        if (tick) begin
          if (LENGTH == 16'd0) begin
            next_state = DONE;
          end else begin
            load       = 1'b1;
            next_state = CMD;
          end
        end
      end
      CMD:  if (cmd_last) next_state = DATA;
      // Last byte written: CS rises with spiCk forced low on the same clock.
      DATA: begin
        if (last_wr) begin
          stop       = 1'b1;
          next_state = DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= START;
      spi_cs   <= 1'b1;
      ini_busy <= 1'b1;
      ini_wr   <= 1'b0;
      ini_d    <= '0;
      ini_a    <= '0;
      index    <= '0;
    end else begin
      state    <= next_state;
      spi_cs   <= !(next_state == CMD || next_state == DATA);
      ini_busy <= (next_state != DONE);
      ini_wr   <= byte_done;
      if (byte_done) begin
        ini_d <= rx_next;
        ini_a <= index;
      end
      if (ini_wr) index <= index + 16'd1;
    end
  end

  assign bus.spiCs   = spi_cs;
  assign bus.spiCk   = spi_ck;
  assign bus.spiDo   = spi_do;
  assign bus.iniBusy = ini_busy;
  assign bus.iniWr   = ini_wr;
  assign bus.iniD    = ini_d;
  assign bus.iniA    = ini_a;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: three loaders (random image, empty image, short fast
// image) against flash models, a protocol checker and a reset-mid-load sequence.
module tb_rom_loader;
  import rom_loader_pkg::*;

  localparam logic [23:0] FADDR_A = 24'hABCDEF;
  localparam logic [15:0] LEN_A   = 16'd40;
  localparam int          DIV_A   = 2;
  localparam logic [15:0] LEN_C   = 16'd3;
  localparam int          DIV_C   = 1;

  int checks = 0;
  int errors = 0;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic rst_a = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  rom_loader_if bus_a ();
  rom_loader_if bus_z ();
  rom_loader_if bus_c ();

  rom_loader #(.FADDR(FADDR_A), .LENGTH(LEN_A), .DIV(DIV_A)) u_a (
    .clock(clock), .reset(rst_a), .bus(bus_a));
  rom_loader #(.LENGTH(16'd0), .DIV(2)) u_z (
    .clock(clock), .reset(rst), .bus(bus_z));
  rom_loader #(.LENGTH(LEN_C), .DIV(DIV_C)) u_c (
    .clock(clock), .reset(rst), .bus(bus_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- flash models ----------------
  logic [7:0]  mem_a [256];
  logic        di_a = 1'b0, di_c = 1'b0;
  int          rises_a = 0, rises_c = 0, cmd_seen_a = 0, cmd_seen_c = 0;
  logic [31:0] cmd_a = '0, cmd_c = '0;

  assign bus_a.spiDi = di_a;
  assign bus_c.spiDi = di_c;
  assign bus_z.spiDi = 1'b0;

  always @(negedge bus_a.spiCs) begin rises_a = 0; cmd_a = '0; end
  always @(negedge bus_c.spiCs) begin rises_c = 0; cmd_c = '0; end

  always @(posedge bus_a.spiCk) if (!bus_a.spiCs) begin
    if (rises_a < 32) cmd_a = {cmd_a[30:0], bus_a.spiDo};
    rises_a++;
    if (rises_a == 32) begin
      cmd_seen_a++;
      check("a_mosi_cmd", cmd_a, {SPI_READ, FADDR_A});
    end
  end

  always @(posedge bus_c.spiCk) if (!bus_c.spiCs) begin
    if (rises_c < 32) cmd_c = {cmd_c[30:0], bus_c.spiDo};
    rises_c++;
    if (rises_c == 32) begin
      cmd_seen_c++;
      check("c_mosi_cmd", cmd_c, {SPI_READ, DEFAULT_FADDR});
    end
  end

  // Mode 0: the flash presents the next data bit after each falling edge.
  always @(negedge bus_a.spiCk) if (!bus_a.spiCs && rises_a >= 32) begin
    int k;
    logic [23:0] fa;
    logic [7:0]  b;
    k  = rises_a - 32;
    fa = cmd_a[23:0] + 24'(k / 8);
    b  = mem_a[fa[7:0]];
    di_a = b[7 - (k % 8)];
  end

  always @(negedge bus_c.spiCk) if (!bus_c.spiCs && rises_c >= 32) begin
    int k;
    logic [23:0] fa;
    logic [7:0]  b;
    k  = rises_c - 32;
    fa = cmd_c[23:0] + 24'(k / 8);
    b  = fa[7:0] ^ 8'hA5;
    di_c = b[7 - (k % 8)];
  end

  // ---------------- protocol checker ----------------
  logic prev_cs [3];
  logic prev_ck [3];
  logic prev_do [3];

  task automatic proto(input int n, input string tag, input logic cs, input logic ck, input logic sdo);
    if (prev_ck[n] === 1'b0 && ck === 1'b1) check({tag, "_mosi_hold"}, sdo, prev_do[n]);
    if (prev_cs[n] !== 1'bx && cs !== prev_cs[n]) check({tag, "_ck_at_cs_edge"}, ck, 0);
    if (cs === 1'b1) check({tag, "_ck_idle"}, ck, 0);
    prev_cs[n] = cs;
    prev_ck[n] = ck;
    prev_do[n] = sdo;
  endtask

  always @(negedge clock) begin
    proto(0, "a", bus_a.spiCs, bus_a.spiCk, bus_a.spiDo);
    proto(1, "z", bus_z.spiCs, bus_z.spiCk, bus_z.spiDo);
    proto(2, "c", bus_c.spiCs, bus_c.spiCk, bus_c.spiDo);
  end

  // ---------------- init-bus monitors ----------------
  int          idx_a = 0, last_cyc_a = 0;
  logic        have_a = 1'b0, wr_prev_a = 1'b0, pend_a = 1'b0;
  logic [15:0] la;
  logic [7:0]  ld;

  always @(negedge clock) begin
    if (rst_a) begin
      idx_a = 0; have_a = 1'b0; wr_prev_a = 1'b0; pend_a = 1'b0;
    end else begin
      if (pend_a) begin
        check("a_busy_drop", bus_a.iniBusy, 0);
        check("a_cs_release", bus_a.spiCs, 1);
        pend_a = 1'b0;
      end
      if (bus_a.iniWr) begin
        check("a_wr_width", wr_prev_a, 0);
        check("a_addr", bus_a.iniA, 32'(idx_a));
        check("a_data", bus_a.iniD, mem_a[8'(FADDR_A[7:0] + 8'(idx_a))]);
        check("a_busy_during", bus_a.iniBusy, 1);
        if (have_a) check("a_spacing", (cyc - last_cyc_a) >= 16 * DIV_A, 1);
        if (idx_a == int'(LEN_A) - 1) pend_a = 1'b1;
        la = bus_a.iniA; ld = bus_a.iniD;
        have_a = 1'b1; last_cyc_a = cyc; idx_a++;
      end else if (have_a) begin
        check("a_addr_hold", bus_a.iniA, la);
        check("a_data_hold", bus_a.iniD, ld);
      end
      wr_prev_a = bus_a.iniWr;
    end
  end

  typedef struct { logic [15:0] a; logic [7:0] d; int cyc; } pulse_t;
  pulse_t q_c[$];
  logic   wr_prev_c = 1'b0, z_cs_seen = 1'b0, z_wr_seen = 1'b0;

  always @(negedge clock) begin
    if (!rst) begin
      if (bus_c.iniWr) begin
        check("c_wr_width", wr_prev_c, 0);
        q_c.push_back('{bus_c.iniA, bus_c.iniD, cyc});
      end
      wr_prev_c = bus_c.iniWr;
      if (bus_z.spiCs === 1'b0) z_cs_seen = 1'b1;
      if (bus_z.iniWr === 1'b1) z_wr_seen = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  typedef struct { logic [15:0] a; logic [7:0] d; int gap; } vec_t;
  vec_t vec_c [3];

  initial begin
    int n;
    logic [15:0] hold_a;

    vec_c[0] = '{16'h0000, 8'hA5, 0};
    vec_c[1] = '{16'h0001, 8'hA4, 16};
    vec_c[2] = '{16'h0002, 8'hA7, 16};
    for (int i = 0; i < 256; i++) mem_a[i] = 8'($urandom);

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_cs", bus_a.spiCs, 1);
    check("rst_ck", bus_a.spiCk, 0);
    check("rst_do", bus_a.spiDo, 0);
    check("rst_busy", bus_a.iniBusy, 1);
    check("rst_wr", bus_a.iniWr, 0);
    check("rst_d", bus_a.iniD, 0);
    check("rst_a", bus_a.iniA, 0);
    rst = 1'b0; rst_a = 1'b0;

    // Empty image: START lasts exactly one tick (DIV=2 clocks).
    @(negedge clock); check("z_busy_first_clk", bus_z.iniBusy, 1);
    @(negedge clock); check("z_busy_after_tick", bus_z.iniBusy, 0);

    // Reset in the middle of byte 5 of the random image.
    n = 0;
    while (idx_a < 4 && n < 5000) begin @(negedge clock); n++; end
    check("a_reached_byte5", idx_a >= 4, 1);
    repeat ($urandom_range(2, 24)) @(posedge clock);
    check("a_pre_reset_addr", bus_a.iniA, 3);
    #2 rst_a = 1'b1;
    #1;
    check("a_async_cs", bus_a.spiCs, 1);
    check("a_async_ck", bus_a.spiCk, 0);
    check("a_async_busy", bus_a.iniBusy, 1);
    check("a_async_addr", bus_a.iniA, 0);
    check("a_async_wr", bus_a.iniWr, 0);
    repeat (3) @(negedge clock);
    rst_a = 1'b0;

    n = 0;
    while (bus_a.iniBusy !== 1'b0 && n < 20000) begin @(negedge clock); n++; end
    check("a_finished_in_budget", bus_a.iniBusy, 0);
    check("a_pulse_count", idx_a, 32'(LEN_A));
    check("a_final_addr", bus_a.iniA, LEN_A - 16'd1);
    check("a_cmd_sessions", cmd_seen_a, 2);
    hold_a = bus_a.iniA;
    repeat (50) @(negedge clock);
    check("a_done_addr", bus_a.iniA, hold_a);
    check("a_done_busy", bus_a.iniBusy, 0);
    check("a_done_cs", bus_a.spiCs, 1);
    check("a_done_ck", bus_a.spiCk, 0);

    // Short image at DIV=1, compared against the vector table.
    check("c_pulse_count", q_c.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < q_c.size()) begin
        check("c_addr", q_c[i].a, vec_c[i].a);
        check("c_data", q_c[i].d, vec_c[i].d);
        if (i > 0) check("c_gap", q_c[i].cyc - q_c[i-1].cyc, vec_c[i].gap);
      end
    end
    check("c_cmd_sessions", cmd_seen_c, 1);
    check("c_done_cs", bus_c.spiCs, 1);
    check("c_done_ck", bus_c.spiCk, 0);
    check("c_done_busy", bus_c.iniBusy, 0);
    check("c_done_addr", bus_c.iniA, 16'h0002);

    check("z_cs_never_low", z_cs_seen, 0);
    check("z_wr_never_high", z_wr_seen, 0);
    check("z_addr", bus_z.iniA, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
